// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle 16-bit mips core: opcodes, FSM states and
// instruction field positions.
package mips_mc_pkg;

  localparam int unsigned INST_W  = 16;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned IMM_W   = 4;

  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_LSB  = 7;
  localparam int unsigned RT_LSB  = 4;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_LW   = 3'b000,
    OP_SW   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_BEQ  = 3'b100,
    OP_ADDI = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    WB     = 3'd3,
    HALTED = 3'd4
  } state_e;

endpackage

// File: rtl/mips_regfile.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one synchronous write
// port; R0 always reads zero and ignores writes.
module mips_regfile
  import mips_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle 16-bit mips core: FETCH/EXEC/MEM/WB sequencer with req/valid handshakes
// to instruction ROM and data RAM, so either memory may insert wait states.
module mips_multicycle
  import mips_mc_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IADDR_W  = 5,
  parameter int unsigned DADDR_W  = 4,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_rdata,
  input  logic               imem_rvalid,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [IADDR_W-1:0] pc,
  output logic               retire,
  output logic               halt
);

  state_e              r_state;
  logic [IADDR_W-1:0]  r_pc;
  logic [INST_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_res;
  logic [DADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]   r_wdata;

  opcode_e             w_op;
  logic [REG_AW-1:0]   w_rd;
  logic [REG_AW-1:0]   w_rs;
  logic [REG_AW-1:0]   w_rt;
  logic [IMM_W-1:0]    w_imm;
  logic [DATA_W-1:0]   w_rs_val;
  logic [DATA_W-1:0]   w_rt_val;
  logic [DATA_W-1:0]   w_alu;
  logic [IADDR_W-1:0]  w_pc_inc;
  logic [IADDR_W-1:0]  w_br_tgt;
  logic                w_rf_we;
  logic                w_retire;

  assign w_op  = opcode_e'(r_ir[OP_LSB +: OP_W]);
  assign w_rd  = r_ir[RD_LSB +: REG_AW];
  assign w_rs  = r_ir[RS_LSB +: REG_AW];
  assign w_rt  = r_ir[RT_LSB +: REG_AW];
  assign w_imm = r_ir[IMM_LSB +: IMM_W];

  assign w_rf_we = (r_state == WB);

  mips_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_we      (w_rf_we),
    .i_waddr   (w_rd),
    .i_wdata   (r_res),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_val),
    .o_rdata_b (w_rt_val)
  );

  // ADDI and the LW/SW address both use rs + zero-extended imm
  always_comb begin
    w_alu = w_rs_val + DATA_W'(w_imm);
    case (w_op)
      OP_ADD:  w_alu = w_rs_val + w_rt_val;
      OP_SUB:  w_alu = w_rs_val - w_rt_val;
      default: w_alu = w_rs_val + DATA_W'(w_imm);
    endcase
  end

  assign w_pc_inc = r_pc + IADDR_W'(1);
  assign w_br_tgt = w_pc_inc + IADDR_W'($signed(w_imm));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= IADDR_W'(RESET_PC);
      r_ir    <= '0;
      r_res   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_rvalid) begin
            r_ir    <= imem_rdata;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_res   <= w_alu;
          r_addr  <= DADDR_W'(w_alu);
          r_wdata <= w_rt_val;
          case (w_op)
            OP_LW, OP_SW:             r_state <= MEM;
            OP_ADD, OP_SUB, OP_ADDI:  r_state <= WB;
            OP_BEQ: begin
              r_pc    <= (w_rs_val == w_rt_val) ? w_br_tgt : w_pc_inc;
              r_state <= FETCH;
            end
            OP_NOP: begin
              r_pc    <= w_pc_inc;
              r_state <= FETCH;
            end
            default:                  r_state <= HALTED;
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            if (w_op == OP_SW) begin
              r_pc    <= w_pc_inc;
              r_state <= FETCH;
            end else begin
              r_res   <= dmem_rdata;
              r_state <= WB;
            end
          end
        end
        WB: begin
          r_pc    <= w_pc_inc;
          r_state <= FETCH;
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Retire marks the completing cycle of each instruction
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      EXEC:    w_retire = (w_op == OP_BEQ) || (w_op == OP_NOP) || (w_op == OP_HALT);
      MEM:     w_retire = dmem_ack && (w_op == OP_SW);
      WB:      w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  assign imem_req   = (r_state == FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == MEM);
  assign dmem_we    = (r_state == MEM) && (w_op == OP_SW);
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign pc         = r_pc;
  assign retire     = w_retire;
  assign halt       = (r_state == HALTED);

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: an 8-bit core with programmable dmem wait states
// plus a 16-bit / 8-bit-PC core with zero-wait memories.
module tb_mips_multicycle;
  import mips_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // 8-bit core
  logic        imem_req, imem_rvalid, dmem_req, dmem_we, dmem_ack, retire, halt;
  logic [4:0]  imem_addr, pc;
  logic [15:0] imem_rdata;
  logic [3:0]  dmem_addr;
  logic [7:0]  dmem_wdata, dmem_rdata;
  logic [15:0] imem8 [0:31];
  logic [7:0]  dmem8 [0:15];

  // 16-bit core
  logic        imem_req16, imem_rvalid16, dmem_req16, dmem_we16, dmem_ack16, retire16, halt16;
  logic [7:0]  imem_addr16, pc16;
  logic [15:0] imem_rdata16;
  logic [3:0]  dmem_addr16;
  logic [15:0] dmem_wdata16, dmem_rdata16;
  logic [15:0] imem16 [0:255];
  logic [15:0] dmem16 [0:15];

  int unsigned ack_wait;
  logic        ack_en, force_ack;
  int unsigned cnt, n_ret, wait_ret, cyc, trace_n, n_acc, cur_len, n_ret16;
  int unsigned first_len;
  logic [3:0]  first_addr;
  logic [7:0]  first_wdata;
  logic        first_we;
  logic [4:0]  trace [0:15];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  assign imem_rvalid  = imem_req;
  assign imem_rdata   = imem8[imem_addr];
  assign dmem_rdata   = dmem8[dmem_addr];
  assign dmem_ack     = force_ack | (dmem_req & ack_en & (cnt >= ack_wait));

  assign imem_rvalid16 = imem_req16;
  assign imem_rdata16  = imem16[imem_addr16];
  assign dmem_rdata16  = dmem16[dmem_addr16];
  assign dmem_ack16    = dmem_req16;

  mips_multicycle #(
    .DATA_W(8), .IADDR_W(5), .DADDR_W(4), .NREGS(8), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .retire(retire), .halt(halt)
  );

  mips_multicycle #(
    .DATA_W(16), .IADDR_W(8), .DADDR_W(4), .NREGS(8), .RESET_PC(0)
  ) dut16 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_rdata(imem_rdata16), .imem_rvalid(imem_rvalid16),
    .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
    .dmem_rdata(dmem_rdata16), .dmem_ack(dmem_ack16),
    .pc(pc16), .retire(retire16), .halt(halt16)
  );

  // Memory models and activity monitors; reset refills data memories with a marker
  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0; n_ret <= 0; wait_ret <= 0; cyc <= 0; trace_n <= 0;
      n_acc <= 0; cur_len <= 0; n_ret16 <= 0;
      for (int i = 0; i < 16; i++) begin
        dmem8[i]  <= 8'hA5;
        dmem16[i] <= 16'hA5A5;
      end
    end else begin
      cyc <= cyc + 1;
      if (retire)   n_ret   <= n_ret + 1;
      if (retire16) n_ret16 <= n_ret16 + 1;
      if (dmem_req && !dmem_ack) begin
        cnt     <= cnt + 1;
        cur_len <= cur_len + 1;
        if (retire) wait_ret <= wait_ret + 1;
      end else begin
        cnt     <= 0;
        cur_len <= 0;
      end
      if (dmem_req && dmem_ack) begin
        if (dmem_we) dmem8[dmem_addr] <= dmem_wdata;
        if (n_acc == 0) begin
          first_len   <= cur_len + 1;
          first_addr  <= dmem_addr;
          first_wdata <= dmem_wdata;
          first_we    <= dmem_we;
        end
        n_acc <= n_acc + 1;
      end
      if (dmem_req16 && dmem_ack16 && dmem_we16) dmem16[dmem_addr16] <= dmem_wdata16;
      if (imem_req && imem_rvalid && trace_n < 16) begin
        trace[trace_n[3:0]] <= imem_addr;
        trace_n <= trace_n + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt,
                                      input logic [3:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem8[i] = enc(OP_NOP, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input bit big, input int unsigned limit, input string tag);
    for (int unsigned i = 0; i < limit; i++) begin
      if (big ? halt16 : halt) break;
      @(negedge clk);
    end
    check_eq(tag, 32'(big ? halt16 : halt), 1);
  endtask

  task automatic wait_trace(input int unsigned n, input int unsigned limit, input string tag);
    for (int unsigned i = 0; i < limit; i++) begin
      if (trace_n >= n) break;
      @(negedge clk);
    end
    check_eq(tag, 32'(trace_n >= n), 1);
  endtask

  initial begin
    reset = 1'b1; ack_en = 1'b1; force_ack = 1'b0; ack_wait = 0;

    // Program 1: ADDI R1,R0,5; ADDI R2,R0,3; ADD R3,R1,R2; HALT
    clear_imem();
    imem8[0] = enc(OP_ADDI, 1, 0, 0, 5);
    imem8[1] = enc(OP_ADDI, 2, 0, 0, 3);
    imem8[2] = enc(OP_ADD,  3, 1, 2, 0);
    imem8[3] = enc(OP_HALT, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) imem16[i] = enc(OP_NOP, 0, 0, 0, 0);
    imem16[0] = enc(OP_ADDI, 2, 0, 0, 1);
    imem16[1] = enc(OP_SUB,  1, 0, 2, 0);   // 0 - 1 = 0xFFFF
    imem16[2] = enc(OP_ADDI, 3, 1, 0, 1);   // 0xFFFF + 1 = 0
    imem16[3] = enc(OP_SW,   0, 0, 1, 3);
    imem16[4] = enc(OP_SW,   0, 0, 3, 2);
    imem16[5] = enc(OP_ADDI, 4, 0, 0, 5);
    imem16[6] = enc(OP_ADDI, 5, 0, 0, 3);
    imem16[7] = enc(OP_ADD,  6, 4, 5, 0);
    imem16[8] = enc(OP_SW,   0, 0, 6, 4);
    imem16[9] = enc(OP_HALT, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_imem_req",  32'(imem_req), 1);
    check_eq("rst_imem_addr", 32'(imem_addr), 0);
    check_eq("rst_pc",        32'(pc), 0);
    check_eq("rst_outs_zero", 32'({dmem_req, dmem_we, dmem_addr, dmem_wdata, retire, halt}), 0);
    reset = 1'b0;
    // 3 ALU ops x 3 cycles, HALT FETCH+EXEC: HALTED after the 11th post-reset edge
    wait_halt(1'b0, 100, "p1_halt");
    check_eq("p1_halt_cycle", cyc, 11);
    check_eq("p1_retires",    n_ret, 4);
    check_eq("p1_pc",         32'(pc), 3);
    check_eq("p1_no_ireq",    32'(imem_req), 0);
    repeat (5) @(negedge clk);
    check_eq("p1_pc_frozen",  32'(pc), 3);
    check_eq("p1_still_halt", 32'(halt), 1);
    check_eq("p1_no_more_ret", n_ret, 4);

    wait_halt(1'b1, 200, "w16_halt");
    check_eq("w16_pc",      32'(pc16), 9);
    check_eq("w16_ffff",    32'(dmem16[3]), 32'h0000FFFF);
    check_eq("w16_wrap0",   32'(dmem16[2]), 0);
    check_eq("w16_add",     32'(dmem16[4]), 8);
    check_eq("w16_retires", n_ret16, 10);

    // Program 2: memory ops with 2 wait states (req held 3 cycles)
    clear_imem();
    imem8[0]  = enc(OP_ADDI, 1, 0, 0, 5);
    imem8[1]  = enc(OP_ADDI, 2, 0, 0, 3);
    imem8[2]  = enc(OP_ADD,  3, 1, 2, 0);
    imem8[3]  = enc(OP_SW,   0, 0, 3, 2);
    imem8[4]  = enc(OP_LW,   4, 0, 0, 2);
    imem8[5]  = enc(OP_SW,   0, 0, 4, 3);
    imem8[6]  = enc(OP_SUB,  5, 2, 1, 0);
    imem8[7]  = enc(OP_SW,   0, 0, 5, 4);
    imem8[8]  = enc(OP_ADD,  0, 1, 1, 0);
    imem8[9]  = enc(OP_SW,   0, 0, 0, 5);
    imem8[10] = enc(OP_HALT, 0, 0, 0, 0);
    ack_wait = 2;
    do_reset();
    wait_halt(1'b0, 300, "p2_halt");
    check_eq("p2_sw_addr",   32'(first_addr), 2);
    check_eq("p2_sw_wdata",  32'(first_wdata), 8);
    check_eq("p2_sw_we",     32'(first_we), 1);
    check_eq("p2_req_len",   first_len, 3);
    check_eq("p2_wait_ret",  wait_ret, 0);
    check_eq("p2_lw_r4",     32'(dmem8[3]), 8);
    check_eq("p2_sub_fe",    32'(dmem8[4]), 32'hFE);
    check_eq("p2_r0_zero",   32'(dmem8[5]), 0);
    check_eq("p2_retires",   n_ret, 11);
    ack_wait = 0;

    // Program 3: BEQ not taken at pc=2, taken -2 at pc=4
    clear_imem();
    imem8[0] = enc(OP_ADDI, 1, 0, 0, 5);
    imem8[1] = enc(OP_ADDI, 2, 0, 0, 3);
    imem8[2] = enc(OP_BEQ,  0, 1, 2, 4'h5);
    imem8[3] = enc(OP_NOP,  0, 0, 0, 0);
    imem8[4] = enc(OP_BEQ,  0, 1, 1, 4'hE);
    do_reset();
    wait_trace(7, 100, "p3_trace");
    check_eq("p3_not_taken", 32'(trace[3]), 3);
    check_eq("p3_taken_m2",  32'(trace[5]), 3);
    check_eq("p3_loop",      32'(trace[6]), 4);

    // Program 4: backward wrap to 30, then branch from 31 with +1 wraps to 1
    clear_imem();
    imem8[0]  = enc(OP_BEQ,  0, 1, 0, 4'hD);
    imem8[30] = enc(OP_ADDI, 1, 0, 0, 1);
    imem8[31] = enc(OP_BEQ,  0, 0, 0, 4'h1);
    imem8[1]  = enc(OP_HALT, 0, 0, 0, 0);
    do_reset();
    wait_halt(1'b0, 100, "p4_halt");
    check_eq("p4_back_wrap", 32'(trace[1]), 30);
    check_eq("p4_pc31",      32'(trace[2]), 31);
    check_eq("p4_fwd_wrap",  32'(trace[3]), 1);
    check_eq("p4_pc",        32'(pc), 1);

    // Program 5: NOP at pc=31 increments to 0
    clear_imem();
    imem8[0] = enc(OP_BEQ, 0, 0, 0, 4'hE);
    do_reset();
    wait_trace(3, 50, "p5_trace");
    check_eq("p5_to31",    32'(trace[1]), 31);
    check_eq("p5_inc_wrap", 32'(trace[2]), 0);

    // Reset during a stalled store, then stray acks outside MEM
    clear_imem();
    imem8[0] = enc(OP_SW,   0, 0, 1, 6);
    imem8[1] = enc(OP_ADDI, 1, 0, 0, 7);
    imem8[2] = enc(OP_BEQ,  0, 0, 0, 4'hD);
    do_reset();
    for (int unsigned i = 0; i < 100 && n_acc == 0; i++) @(negedge clk);
    check_eq("rst_first_acc", n_acc, 1);
    ack_en = 1'b0;
    for (int unsigned i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
    check_eq("rst_mem_reach", 32'(dmem_req), 1);
    check_eq("rst_pre_wdata", 32'(dmem_wdata), 7);
    repeat (2) @(negedge clk);
    check_eq("rst_req_held",  32'(dmem_req), 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_dreq",  32'(dmem_req), 0);
    check_eq("rst_mid_ireq",  32'(imem_req), 1);
    check_eq("rst_mid_pc",    32'(pc), 0);
    reset = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    check_eq("stray_exec_ret", 32'(retire), 0);
    @(negedge clk);
    force_ack = 1'b0;
    check_eq("stray_in_mem",   32'(dmem_req), 1);
    check_eq("stray_no_acc",   n_acc, 0);
    @(negedge clk);
    check_eq("stray_mem_hold", 32'(dmem_req), 1);
    check_eq("stray_no_ret",   n_ret, 0);
    check_eq("rst_regs_zero",  32'(dmem_wdata), 0);
    ack_en = 1'b1;
    @(negedge clk);
    check_eq("rst_store_done", n_acc, 1);
    check_eq("rst_store_addr", 32'(first_addr), 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
